rmw_memory_controller: RTL and testbench

- Successor CPU-to-RAM data-path controller between the core's load/store port and a single-port, word-wide synchronous RAM.
- Adds byte, halfword and word accesses at any byte address, including accesses that span two RAM words.
- Adds sign/zero extension on loads, read-modify-write for partial stores, and real ReadOK/WriteOK handshakes in place of tied-high acknowledges.
- Optional strict-alignment mode reports faults instead of splitting accesses.

---
 rtl/rmw_memory_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_rmw_memory_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_memory_controller.sv
// CPU load/store to single-port word RAM controller with sub-word access,
// word-spanning split, load extension and read-modify-write partial stores.
module rmw_memory_controller #(
    parameter int unsigned MEM_ADDR_WIDTH   = 14,
    parameter int unsigned ALLOW_MISALIGNED = 1
) (
    input  logic                      CoreClock,
    input  logic                      CoreResetN,
    input  logic [31:0]               CpuAddress,
    input  logic [31:0]               CpuWriteData,
    input  logic [1:0]                CpuSize,
    input  logic                      CpuReadSigned,
    input  logic                      CpuReadRequest,
    input  logic                      CpuWriteAssert,
    output logic [31:0]               CpuReadData,
    output logic                      CpuReadOK,
    output logic                      CpuWriteOK,
    output logic                      CpuAlignFault,
    output logic [MEM_ADDR_WIDTH-1:0] MemAddress,
    output logic [31:0]               MemWriteData,
    output logic                      MemWriteAssert,
    input  logic [31:0]               MemReadData
);

    localparam int unsigned AW       = MEM_ADDR_WIDTH;
    localparam int unsigned DW       = 32;
    localparam bit          SPLIT_EN = (ALLOW_MISALIGNED != 0);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_WRD0, S_WWB0, S_WRD1, S_WWB1, S_ACK
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          span_q, span_d;
    logic          signed_q, signed_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] word0_q, word0_d;
    logic          rd_ok_q, rd_ok_d;
    logic          wr_ok_q, wr_ok_d;
    logic          fault_q, fault_d;

    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic          mem_we_c;

    // True when an access of the given size at the given offset crosses a word
    function automatic logic spans(input logic [1:0] off, input logic [1:0] sz);
        case (sz)
            SZ_BYTE: spans = 1'b0;
            SZ_HALF: spans = (off == 2'd3);
            default: spans = (off != 2'd0);
        endcase
    endfunction

    // Right-justified lane mask for an access size
    function automatic logic [DW-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = 32'h0000_00FF;
            SZ_HALF: size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Live request decode, used only while idle
    logic [AW-1:0] req_idx_c;
    logic [1:0]    req_off_c;
    logic [1:0]    req_size_c;
    logic          req_span_c;
    logic          unused_addr_c;

    assign req_idx_c     = CpuAddress[AW+1:2];
    assign req_off_c     = CpuAddress[1:0];
    assign req_size_c    = (CpuSize == 2'b11) ? SZ_WORD : CpuSize;
    assign req_span_c    = spans(req_off_c, req_size_c);
    assign unused_addr_c = ^CpuAddress[31:AW+2];

    // Store merge: shifted data and lane mask over the two-word window
    logic [4:0]    shamt_c;
    logic [63:0]   wdata64_c;
    logic [63:0]   mask64_c;
    logic [DW-1:0] merge_lo_c;
    logic [DW-1:0] merge_hi_c;

    assign shamt_c    = {off_q, 3'b000};
    assign wdata64_c  = 64'(wdata_q) << shamt_c;
    assign mask64_c   = 64'(size_mask(size_q)) << shamt_c;
    assign merge_lo_c = (MemReadData & ~mask64_c[31:0])  | (wdata64_c[31:0]  & mask64_c[31:0]);
    assign merge_hi_c = (MemReadData & ~mask64_c[63:32]) | (wdata64_c[63:32] & mask64_c[63:32]);

    // Load extraction from {hi, lo}; hi is the live RAM word in RD1
    logic [DW-1:0] load_lo_c;
    logic [DW-1:0] load_shift_c;
    logic [DW-1:0] load_ext_c;

    assign load_lo_c    = span_q ? word0_q : MemReadData;
    assign load_shift_c = 32'({MemReadData, load_lo_c} >> shamt_c);

    // Truncate to access size, then sign- or zero-extend
    always_comb begin
        load_ext_c = load_shift_c;
        case (size_q)
            SZ_BYTE: load_ext_c = signed_q ? {{24{load_shift_c[7]}}, load_shift_c[7:0]}
                                           : {24'h0, load_shift_c[7:0]};
            SZ_HALF: load_ext_c = signed_q ? {{16{load_shift_c[15]}}, load_shift_c[15:0]}
                                           : {16'h0, load_shift_c[15:0]};
            default: load_ext_c = load_shift_c;
        endcase
    end

    // Next-state, request capture and RAM port drive
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        off_d       = off_q;
        size_d      = size_q;
        span_d      = span_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        rd_ok_d     = 1'b0;
        wr_ok_d     = 1'b0;
        fault_d     = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_we_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CoreResetN && (CpuWriteAssert || CpuReadRequest)) begin
                    idx_d      = req_idx_c;
                    off_d      = req_off_c;
                    size_d     = req_size_c;
                    span_d     = req_span_c;
                    signed_d   = CpuReadSigned;
                    wdata_d    = CpuWriteData;
                    mem_addr_c = req_idx_c;
                    if (CpuWriteAssert) begin
                        if (req_span_c && !SPLIT_EN) begin
                            state_d = S_ACK;
                            wr_ok_d = 1'b1;
                            fault_d = 1'b1;
                        end else if ((req_off_c == 2'd0) && (req_size_c == SZ_WORD)) begin
                            mem_we_c    = 1'b1;
                            mem_wdata_c = CpuWriteData;
                            state_d     = S_ACK;
                            wr_ok_d     = 1'b1;
                        end else begin
                            state_d = S_WWB0;
                        end
                    end else begin
                        if (req_span_c && !SPLIT_EN) begin
                            state_d = S_ACK;
                            rd_ok_d = 1'b1;
                            fault_d = 1'b1;
                        end else if (req_span_c) begin
                            state_d = S_RD0;
                        end else begin
                            state_d = S_RD1;
                            rd_ok_d = 1'b1;
                        end
                    end
                end
            end
            S_RD0: begin
                word0_d    = MemReadData;
                mem_addr_c = idx_q + AW'(1);
                state_d    = S_RD1;
                rd_ok_d    = 1'b1;
            end
            S_RD1: begin
                state_d = S_IDLE;
            end
            S_WWB0: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = idx_q;
                mem_wdata_c = merge_lo_c;
                state_d     = span_q ? S_WRD1 : S_ACK;
                wr_ok_d     = !span_q;
            end
            S_WRD1: begin
                mem_addr_c = idx_q + AW'(1);
                state_d    = S_WWB1;
            end
            S_WWB1: begin
                mem_we_c    = 1'b1;
                mem_addr_c  = idx_q + AW'(1);
                mem_wdata_c = merge_hi_c;
                state_d     = S_ACK;
                wr_ok_d     = 1'b1;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured request and handshake flops
    always_ff @(posedge CoreClock or negedge CoreResetN) begin
        if (!CoreResetN) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            span_q   <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            word0_q  <= '0;
            rd_ok_q  <= 1'b0;
            wr_ok_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            span_q   <= span_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            word0_q  <= word0_d;
            rd_ok_q  <= rd_ok_d;
            wr_ok_q  <= wr_ok_d;
            fault_q  <= fault_d;
        end
    end

    assign CpuReadOK      = rd_ok_q;
    assign CpuWriteOK     = wr_ok_q;
    assign CpuAlignFault  = fault_q;
    assign CpuReadData    = (rd_ok_q && !fault_q) ? load_ext_c : '0;
    assign MemAddress     = mem_addr_c;
    assign MemWriteData   = mem_wdata_c;
    assign MemWriteAssert = mem_we_c;

endmodule

// File: tb/tb_rmw_memory_controller.sv
// Directed bench for rmw_memory_controller: split-mode and strict-mode instances.
module tb_rmw_memory_controller;

    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: misaligned accesses split
    logic [31:0]   a_addr, a_wdata, a_rdata, a_mwdata, a_mrdata;
    logic [1:0]    a_size;
    logic          a_signed, a_rreq, a_wreq, a_rok, a_wok, a_fault, a_mwe;
    logic [AW-1:0] a_maddr;

    // Instance B: strict alignment
    logic [31:0]   b_addr, b_wdata, b_rdata, b_mwdata, b_mrdata;
    logic [1:0]    b_size;
    logic          b_signed, b_rreq, b_wreq, b_rok, b_wok, b_fault, b_mwe;
    logic [AW-1:0] b_maddr;

    rmw_memory_controller #(.MEM_ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1)) dut_a (
        .CoreClock(clk), .CoreResetN(rst_n),
        .CpuAddress(a_addr), .CpuWriteData(a_wdata), .CpuSize(a_size),
        .CpuReadSigned(a_signed), .CpuReadRequest(a_rreq), .CpuWriteAssert(a_wreq),
        .CpuReadData(a_rdata), .CpuReadOK(a_rok), .CpuWriteOK(a_wok), .CpuAlignFault(a_fault),
        .MemAddress(a_maddr), .MemWriteData(a_mwdata), .MemWriteAssert(a_mwe),
        .MemReadData(a_mrdata)
    );

    rmw_memory_controller #(.MEM_ADDR_WIDTH(AW), .ALLOW_MISALIGNED(0)) dut_b (
        .CoreClock(clk), .CoreResetN(rst_n),
        .CpuAddress(b_addr), .CpuWriteData(b_wdata), .CpuSize(b_size),
        .CpuReadSigned(b_signed), .CpuReadRequest(b_rreq), .CpuWriteAssert(b_wreq),
        .CpuReadData(b_rdata), .CpuReadOK(b_rok), .CpuWriteOK(b_wok), .CpuAlignFault(b_fault),
        .MemAddress(b_maddr), .MemWriteData(b_mwdata), .MemWriteAssert(b_mwe),
        .MemReadData(b_mrdata)
    );

    // Synchronous RAM models with a backdoor write port for preloading
    logic [31:0]   ram_a [0:DEPTH-1];
    logic [31:0]   ram_b [0:DEPTH-1];
    logic          bd_a_we, bd_b_we;
    logic [AW-1:0] bd_a_addr, bd_b_addr;
    logic [31:0]   bd_a_data, bd_b_data;
    logic          b_we_seen;

    always @(posedge clk) begin
        if (a_mwe)   ram_a[a_maddr]   <= a_mwdata;
        if (bd_a_we) ram_a[bd_a_addr] <= bd_a_data;
        a_mrdata <= ram_a[a_maddr];
    end

    always @(posedge clk) begin
        if (b_mwe)   ram_b[b_maddr]   <= b_mwdata;
        if (bd_b_we) ram_b[bd_b_addr] <= bd_b_data;
        b_mrdata <= ram_b[b_maddr];
    end

    // Sticky record of any strict-instance RAM write
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     b_we_seen <= 1'b0;
        else if (b_mwe) b_we_seen <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd_a(input logic [AW-1:0] addr, input logic [31:0] data);
        bd_a_addr = addr; bd_a_data = data; bd_a_we = 1'b1;
        tick();
        bd_a_we = 1'b0;
    endtask

    task automatic bd_b(input logic [AW-1:0] addr, input logic [31:0] data);
        bd_b_addr = addr; bd_b_data = data; bd_b_we = 1'b1;
        tick();
        bd_b_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_addr = '0; a_wdata = '0; a_size = '0; a_signed = 1'b0; a_rreq = 1'b0; a_wreq = 1'b0;
        b_addr = '0; b_wdata = '0; b_size = '0; b_signed = 1'b0; b_rreq = 1'b0; b_wreq = 1'b0;
        bd_a_we = 1'b0; bd_a_addr = '0; bd_a_data = '0;
        bd_b_we = 1'b0; bd_b_addr = '0; bd_b_data = '0;
        tick(); tick();

        // Reset values
        chk("rst_rok",    32'(a_rok),    32'h0);
        chk("rst_wok",    32'(a_wok),    32'h0);
        chk("rst_fault",  32'(a_fault),  32'h0);
        chk("rst_mwe",    32'(a_mwe),    32'h0);
        chk("rst_maddr",  32'(a_maddr),  32'h0);
        chk("rst_mwdata", a_mwdata,      32'h0);
        chk("rst_rdata",  a_rdata,       32'h0);
        rst_n = 1'b1;
        tick();

        // Aligned word store 0xDEADBEEF @0x100
        a_addr = 32'h100; a_wdata = 32'hDEADBEEF; a_size = 2'b10; a_wreq = 1'b1;
        #1;
        chk("wst_mwe_t",   32'(a_mwe),   32'h1);
        chk("wst_maddr_t", 32'(a_maddr), 32'h40);
        chk("wst_mwd_t",   a_mwdata,     32'hDEADBEEF);
        chk("wst_wok_t",   32'(a_wok),   32'h0);
        tick();
        chk("wst_wok_t1",  32'(a_wok),   32'h1);
        chk("wst_mwe_t1",  32'(a_mwe),   32'h0);
        a_wreq = 1'b0;
        tick();
        chk("wst_wok_idle", 32'(a_wok),  32'h0);
        chk("wst_ram",      ram_a[14'h40], 32'hDEADBEEF);

        // Word load @0x100
        a_addr = 32'h100; a_size = 2'b10; a_signed = 1'b0; a_rreq = 1'b1;
        #1;
        chk("wld_maddr_t", 32'(a_maddr), 32'h40);
        chk("wld_rok_t",   32'(a_rok),   32'h0);
        tick();
        chk("wld_rok_t1",  32'(a_rok),   32'h1);
        chk("wld_data",    a_rdata,      32'hDEADBEEF);
        a_rreq = 1'b0;
        tick();
        chk("wld_rok_idle", 32'(a_rok),  32'h0);

        // Byte store 0x55 @0x101 (read-modify-write)
        a_addr = 32'h101; a_wdata = 32'h0000_0055; a_size = 2'b00; a_wreq = 1'b1;
        #1;
        chk("bst_mwe_t", 32'(a_mwe), 32'h0);
        tick();
        chk("bst_mwe_t1", 32'(a_mwe), 32'h1);
        chk("bst_mwd_t1", a_mwdata,   32'hDEAD55EF);
        chk("bst_wok_t1", 32'(a_wok), 32'h0);
        tick();
        chk("bst_wok_t2", 32'(a_wok), 32'h1);
        a_wreq = 1'b0;
        tick();
        chk("bst_ram", ram_a[14'h40], 32'hDEAD55EF);

        // Byte loads @0x101, signed and unsigned
        bd_a(14'h40, 32'hDEAD80EF);
        a_addr = 32'h101; a_size = 2'b00; a_signed = 1'b1; a_rreq = 1'b1;
        tick();
        chk("bld_s_rok",  32'(a_rok), 32'h1);
        chk("bld_s_data", a_rdata,    32'hFFFFFF80);
        a_rreq = 1'b0;
        tick();
        a_signed = 1'b0; a_rreq = 1'b1;
        tick();
        chk("bld_u_data", a_rdata, 32'h00000080);
        a_rreq = 1'b0;
        tick();

        // Spanning word load @0x103
        bd_a(14'h40, 32'h44332211);
        bd_a(14'h41, 32'h88776655);
        a_addr = 32'h103; a_size = 2'b10; a_rreq = 1'b1;
        #1;
        chk("sld_maddr_t", 32'(a_maddr), 32'h40);
        tick();
        chk("sld_maddr_t1", 32'(a_maddr), 32'h41);
        chk("sld_rok_t1",   32'(a_rok),   32'h0);
        tick();
        chk("sld_rok_t2",   32'(a_rok),   32'h1);
        chk("sld_data",     a_rdata,      32'h77665544);
        a_rreq = 1'b0;
        tick();

        // Spanning halfword store 0xABCD @0x107 over zeroed RAM
        bd_a(14'h41, 32'h0);
        bd_a(14'h42, 32'h0);
        a_addr = 32'h107; a_wdata = 32'h0000ABCD; a_size = 2'b01; a_wreq = 1'b1;
        tick();
        chk("shs_wwb0_mwe", 32'(a_mwe),   32'h1);
        chk("shs_wwb0_mwd", a_mwdata,     32'hCD000000);
        tick();
        chk("shs_wrd1_mwe", 32'(a_mwe),   32'h0);
        chk("shs_wrd1_ma",  32'(a_maddr), 32'h42);
        tick();
        chk("shs_wwb1_mwd", a_mwdata,     32'h000000AB);
        chk("shs_wok_t3",   32'(a_wok),   32'h0);
        tick();
        chk("shs_wok_t4",   32'(a_wok),   32'h1);
        a_wreq = 1'b0;
        tick();
        chk("shs_ram41", ram_a[14'h41], 32'hCD000000);
        chk("shs_ram42", ram_a[14'h42], 32'h000000AB);

        // Word load @0xFFFE wraps to word 0
        bd_a(14'h3FFF, 32'h11112222);
        bd_a(14'h0000, 32'h33334444);
        a_addr = 32'h0000FFFE; a_size = 2'b10; a_rreq = 1'b1;
        #1;
        chk("wrap_ma_t", 32'(a_maddr), 32'h3FFF);
        tick();
        chk("wrap_ma_t1", 32'(a_maddr), 32'h0);
        tick();
        chk("wrap_data", a_rdata, 32'h44441111);
        a_rreq = 1'b0;
        tick();

        // Strict mode: spanning word store and load fault
        bd_b(14'h40, 32'hAAAAAAAA);
        bd_b(14'h41, 32'hBBBBBBBB);
        b_addr = 32'h102; b_wdata = 32'h12345678; b_size = 2'b10; b_wreq = 1'b1;
        #1;
        chk("strict_mwe_t", 32'(b_mwe), 32'h0);
        tick();
        chk("strict_wok",   32'(b_wok),   32'h1);
        chk("strict_fault", 32'(b_fault), 32'h1);
        chk("strict_mwe_t1", 32'(b_mwe),  32'h0);
        b_wreq = 1'b0;
        tick();
        chk("strict_fault_clr", 32'(b_fault), 32'h0);
        chk("strict_ram40", ram_b[14'h40], 32'hAAAAAAAA);
        chk("strict_ram41", ram_b[14'h41], 32'hBBBBBBBB);
        b_rreq = 1'b1;
        tick();
        chk("strict_rd_rok",   32'(b_rok),   32'h1);
        chk("strict_rd_fault", 32'(b_fault), 32'h1);
        chk("strict_rd_data",  b_rdata,      32'h0);
        b_rreq = 1'b0;
        tick();
        chk("strict_no_we", 32'(b_we_seen), 32'h0);

        // Read and write together: write first, then read
        bd_a(14'h80, 32'hFFFFFFFF);
        a_addr = 32'h200; a_wdata = 32'h5A5A1234; a_size = 2'b01; a_signed = 1'b0;
        a_wreq = 1'b1; a_rreq = 1'b1;
        tick();
        chk("rw_wwb0_mwd", a_mwdata,   32'hFFFF1234);
        chk("rw_rok_wwb0", 32'(a_rok), 32'h0);
        tick();
        chk("rw_wok",      32'(a_wok), 32'h1);
        chk("rw_rok_ack",  32'(a_rok), 32'h0);
        a_wreq = 1'b0;
        tick();
        chk("rw_rd_ma",    32'(a_maddr), 32'h80);
        chk("rw_rd_mwe",   32'(a_mwe),   32'h0);
        tick();
        chk("rw_rok",      32'(a_rok), 32'h1);
        chk("rw_rdata",    a_rdata,    32'h00001234);
        a_rreq = 1'b0;
        tick();

        // Reset during WRD1 of a spanning word store
        bd_a(14'h90, 32'h11111111);
        bd_a(14'h91, 32'h22222222);
        a_addr = 32'h241; a_wdata = 32'hAABBCCDD; a_size = 2'b10; a_wreq = 1'b1;
        tick();
        chk("rmr_wwb0_mwd", a_mwdata, 32'hBBCCDD11);
        tick();
        chk("rmr_wrd1_ma", 32'(a_maddr), 32'h91);
        rst_n = 1'b0; a_wreq = 1'b0;
        #1;
        chk("rmr_mwe",   32'(a_mwe),    32'h0);
        chk("rmr_ma",    32'(a_maddr),  32'h0);
        chk("rmr_mwd",   a_mwdata,      32'h0);
        chk("rmr_wok",   32'(a_wok),    32'h0);
        chk("rmr_rok",   32'(a_rok),    32'h0);
        chk("rmr_fault", 32'(a_fault),  32'h0);
        chk("rmr_rdata", a_rdata,       32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rmr_wok_after", 32'(a_wok), 32'h0);
        tick();
        chk("rmr_ram90", ram_a[14'h90], 32'hBBCCDD11);
        chk("rmr_ram91", ram_a[14'h91], 32'h22222222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
